// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the register file / ALU datapath: accepts one decoded
// operation in WAIT and sequences register reads, ALU execute and writeback.
module datapath_sequencer #(
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [1:0]        mode,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        aluop_in,
  input  logic [1:0]        shift_in,
  output logic              w,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              vsel,
  output logic [1:0]        aluop,
  output logic [1:0]        shift
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_LOAD_A    = 3'd1;
  localparam logic [2:0] S_LOAD_B    = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_WRITE_IMM = 3'd5;

  localparam logic [1:0] M_ALU  = 2'b00;
  localparam logic [1:0] M_CMP  = 2'b01;
  localparam logic [1:0] M_IMM  = 2'b10;
  localparam logic [1:0] M_SHFT = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rn_q, rn_d;
  logic [REG_AW-1:0] rm_q, rm_d;
  logic [1:0]        aluop_q, aluop_d;
  logic [1:0]        shift_q, shift_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    aluop_d = aluop_q;
    shift_d = shift_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          mode_d  = mode;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          aluop_d = aluop_in;
          shift_d = shift_in;
          case (mode)
            M_IMM:   state_d = S_WRITE_IMM;
            M_SHFT:  state_d = S_LOAD_B;
            default: state_d = S_LOAD_A;
          endcase
        end
      end
      S_LOAD_A:    state_d = S_LOAD_B;
      S_LOAD_B:    state_d = S_EXEC;
      S_EXEC:      state_d = (mode_q == M_CMP) ? S_WAIT : S_WRITE;
      S_WRITE:     state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      mode_q  <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      aluop_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      aluop_q <= aluop_d;
      shift_q <= shift_d;
    end
  end

  // Moore outputs; reset forces WAIT and clears captured fields, so reset values fall out.
  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    aluop    = aluop_q;
    shift    = shift_q;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_LOAD_A: begin
        readnum = rn_q;
        loada   = 1'b1;
      end
      S_LOAD_B: begin
        readnum = rm_q;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        loads = 1'b1;
        if (mode_q == M_SHFT) begin
          asel  = 1'b1;
          aluop = 2'b00;
        end
      end
      S_WRITE: begin
        writenum = rd_q;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = rd_q;
        write    = 1'b1;
        vsel     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural 8x16 datapath driven by the DUT controls,
// plus a queue of expected per-cycle control vectors.
module tb_datapath_sequencer;

  localparam int unsigned AW = 3;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] readnum;
    logic [AW-1:0] writenum;
    logic          write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [1:0]    aluop;
    logic [1:0]    shift;
  } ctl_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] rd = '0, rn = '0, rm = '0;
  logic [1:0]    aluop_in = '0, shift_in = '0;
  logic          w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [AW-1:0] readnum, writenum;
  logic [1:0]    aluop, shift;
  logic [15:0]   datapath_in = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ctl_t exp_q[$];
  ctl_t obs;

  datapath_sequencer #(.REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .s(s), .mode(mode), .rd(rd), .rn(rn), .rm(rm),
    .aluop_in(aluop_in), .shift_in(shift_in), .w(w), .readnum(readnum),
    .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
    .aluop(aluop), .shift(shift)
  );

  always #5 clk = ~clk;

  always_comb obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                     asel, bsel, vsel, aluop, shift};

  // Behavioural datapath: register file, A/B/C pipeline registers, shifter, ALU, Z flag.
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, bsh, ain, bin, alu_out;
  logic        zf;

  always_comb begin
    case (shift)
      2'b00:   bsh = rb;
      2'b01:   bsh = {rb[14:0], 1'b0};
      2'b10:   bsh = {1'b0, rb[15:1]};
      default: bsh = {rb[15], rb[15:1]};
    endcase
    ain = asel ? 16'd0 : ra;
    bin = bsel ? datapath_in : bsh;
    case (aluop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (write) rf[writenum] <= vsel ? datapath_in : rc;
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu_out;
    if (loads) zf <= (alu_out == 16'd0);
  end

  function automatic ctl_t base(input logic [1:0] aop, input logic [1:0] sh);
    ctl_t v = '0;
    v.aluop = aop;
    v.shift = sh;
    return v;
  endfunction

  task automatic push_op(input logic [1:0] md, input logic [AW-1:0] d, input logic [AW-1:0] n,
                         input logic [AW-1:0] m, input logic [1:0] aop, input logic [1:0] sh);
    ctl_t v;
    if (md == 2'b10) begin
      v = base(aop, sh); v.writenum = d; v.write = 1'b1; v.vsel = 1'b1; exp_q.push_back(v);
    end else begin
      if (md != 2'b11) begin
        v = base(aop, sh); v.readnum = n; v.loada = 1'b1; exp_q.push_back(v);
      end
      v = base(aop, sh); v.readnum = m; v.loadb = 1'b1; exp_q.push_back(v);
      v = base(aop, sh); v.loadc = 1'b1; v.loads = 1'b1;
      if (md == 2'b11) begin v.asel = 1'b1; v.aluop = 2'b00; end
      exp_q.push_back(v);
      if (md != 2'b01) begin
        v = base(aop, sh); v.writenum = d; v.write = 1'b1; exp_q.push_back(v);
      end
    end
    v = base(aop, sh); v.w = 1'b1; exp_q.push_back(v);
  endtask

  task automatic chk_ctl(input string tag);
    ctl_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push_reset_vec();
    ctl_t v = '0;
    v.w = 1'b1;
    exp_q.push_back(v);
  endtask

  // Starts an op and checks every cycle up to and including the return to WAIT.
  // keep_s holds s high throughout; otherwise fields are scrambled after accept
  // and s is raised only during cycle index pulse_at.
  task automatic run_op(input string tag, input logic [1:0] md, input logic [AW-1:0] d,
                        input logic [AW-1:0] n, input logic [AW-1:0] m,
                        input logic [1:0] aop, input logic [1:0] sh,
                        input int pulse_at, input bit keep_s);
    int cnt;
    mode = md; rd = d; rn = n; rm = m; aluop_in = aop; shift_in = sh; s = 1'b1;
    push_op(md, d, n, m, aop, sh);
    cnt = exp_q.size();
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      chk_ctl($sformatf("%s_c%0d", tag, i));
      if (!keep_s) begin
        s = (i + 1 == pulse_at);
        if (i == 0) begin
          mode = 2'($urandom); rd = AW'($urandom); rn = AW'($urandom);
          rm = AW'($urandom); aluop_in = 2'($urandom); shift_in = 2'($urandom);
        end
      end
    end
  endtask

  initial begin
    #1;
    push_reset_vec(); chk_ctl("reset_hold");
    @(posedge clk); #1;
    push_reset_vec(); chk_ctl("reset_hold_edge");
    #3 reset = 1'b0;
    @(posedge clk); #1;
    push_reset_vec(); chk_ctl("idle_after_reset");

    datapath_in = 16'd77;
    run_op("imm_r3", 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, -1, 1'b0);
    chk_val("r3_imm", rf[3], 16'd77);
    datapath_in = 16'd42;
    run_op("imm_r1", 2'b10, 3'd1, 3'd0, 3'd0, 2'b00, 2'b00, -1, 1'b0);
    datapath_in = 16'd7;
    run_op("imm_r2", 2'b10, 3'd2, 3'd0, 3'd0, 2'b00, 2'b00, -1, 1'b0);
    datapath_in = 16'd99;
    run_op("imm_r4", 2'b10, 3'd4, 3'd0, 3'd0, 2'b00, 2'b00, -1, 1'b0);
    datapath_in = 16'd500;
    chk_val("r1_pre", rf[1], 16'd42);
    chk_val("r2_pre", rf[2], 16'd7);

    run_op("add_r5", 2'b00, 3'd5, 3'd1, 3'd2, 2'b00, 2'b00, -1, 1'b0);
    chk_val("r5_sum", rf[5], 16'd49);

    run_op("cmp_r5", 2'b01, 3'd6, 3'd5, 3'd5, 2'b01, 2'b00, -1, 1'b0);
    chk_val("cmp_zflag", {15'd0, zf}, 16'd1);
    chk_val("cmp_r6_untouched", rf[6] === 16'd14 ? 16'd1 : 16'd0, 16'd0);

    run_op("mov_shl_r6", 2'b11, 3'd6, 3'd3, 3'd2, 2'b01, 2'b01, -1, 1'b0);
    chk_val("r6_shl", rf[6], 16'd14);

    // s pulsed during EXEC must be ignored; WAIT then persists.
    run_op("busy_sub_r7", 2'b00, 3'd7, 3'd1, 3'd2, 2'b01, 2'b00, 2, 1'b0);
    s = 1'b0;
    push_op(2'b00, 3'd7, 3'd1, 3'd2, 2'b01, 2'b00);
    exp_q.delete(0);
    exp_q.delete(0);
    exp_q.delete(0);
    exp_q.delete(0);
    @(posedge clk); #1; chk_ctl("busy_no_extra_op");
    chk_val("r7_sub", rf[7], 16'd35);

    run_op("b2b_and_r7", 2'b00, 3'd7, 3'd1, 3'd2, 2'b10, 2'b00, -1, 1'b1);
    run_op("b2b_shr_r0", 2'b11, 3'd0, 3'd5, 3'd1, 2'b11, 2'b10, -1, 1'b0);
    chk_val("r7_and", rf[7], 16'd2);
    chk_val("r0_shr", rf[0], 16'd21);

    // Asynchronous reset mid-operation targeting R4.
    mode = 2'b00; rd = 3'd4; rn = 3'd1; rm = 3'd2; aluop_in = 2'b00; shift_in = 2'b00; s = 1'b1;
    push_op(2'b00, 3'd4, 3'd1, 3'd2, 2'b00, 2'b00);
    @(posedge clk); #1; chk_ctl("rst_op_load_a");
    s = 1'b0;
    @(posedge clk); #1; chk_ctl("rst_op_load_b");
    exp_q.delete();
    #2 reset = 1'b1;
    #1; push_reset_vec(); chk_ctl("async_reset_offedge");
    @(posedge clk); #1; push_reset_vec(); chk_ctl("async_reset_held");
    #3 reset = 1'b0;
    @(posedge clk); #1; push_reset_vec(); chk_ctl("post_reset_wait1");
    @(posedge clk); #1; push_reset_vec(); chk_ctl("post_reset_wait2");
    chk_val("r4_unchanged", rf[4], 16'd99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller for the 8x16 register file / ALU datapath.
- Accepts one decoded operation per request and drives register-file read/write, pipeline-register loads and operand/writeback selects, one micro-step per clock.
- Sits between instruction decode (or a bench) and the datapath; the datapath has no control logic of its own.

Parameters:
- REG_AW, 3, width of register-number fields (2**REG_AW registers)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- s  input  1  start request; sampled only in WAIT
- mode  input  2  00 ALU op + writeback, 01 compare (status only), 10 move immediate, 11 move shifted register
- rd  input  REG_AW  destination register
- rn  input  REG_AW  first source (A operand)
- rm  input  REG_AW  second source (B operand, shifted)
- aluop_in  input  2  ALU function, captured at accept
- shift_in  input  2  shifter function, captured at accept
- w  output  1  1 only in WAIT (ready for new request)
- readnum  output  REG_AW  register-file read address
- writenum  output  REG_AW  register-file write address
- write  output  1  register-file write enable
- loada, loadb, loadc, loads  output  1 each  load enables for A, B, C, status
- asel  output  1  1 forces A operand to zero
- bsel  output  1  1 selects immediate for B operand (held 0 by this block)
- vsel  output  1  writeback source: 0 = C, 1 = immediate input
- aluop  output  2  captured ALU function
- shift  output  2  captured shift function

Behaviour:
- States: WAIT, LOAD_A, LOAD_B, EXEC, WRITE, WRITE_IMM. Moore outputs, combinational from state and captured fields.
- Accept: in WAIT with s=1 at a rising edge, capture mode/rd/rn/rm/aluop_in/shift_in and leave WAIT. s outside WAIT is ignored; input changes after accept have no effect.
- Transitions:
  - mode 00: WAIT->LOAD_A->LOAD_B->EXEC->WRITE->WAIT. Write occurs 4 cycles after accept.
  - mode 01: WAIT->LOAD_A->LOAD_B->EXEC->WAIT. 3 cycles, no write.
  - mode 10: WAIT->WRITE_IMM->WAIT. 1 cycle.
  - mode 11: WAIT->LOAD_B->EXEC->WRITE->WAIT. 3 cycles.
- Per-state outputs; anything not listed is 0:
  - WAIT: w=1.
  - LOAD_A: readnum=rn, loada=1.
  - LOAD_B: readnum=rm, loadb=1.
  - EXEC: loadc=1, loads=1, asel=1 iff mode 11. Mode 11 forces aluop=00 (add).
  - WRITE: writenum=rd, write=1, vsel=0.
  - WRITE_IMM: writenum=rd, write=1, vsel=1.
- readnum and writenum are 0 in states that do not use them. aluop and shift are always driven from the captured values.
- bsel is always 0.
- Back-to-back requests: s held high across the return to WAIT is accepted at the first edge in WAIT. w is high for at least one cycle between operations.
- Reset:
  - Async; takes effect immediately in any state, including mid-operation.
  - State goes to WAIT and captured fields clear to 0.
  - While reset is high: w=1, all other outputs 0.
  - An interrupted operation is abandoned; no partial write is issued after reset deasserts.
- Only legal encodings exist for mode (2 bits, all four defined). Unreachable state encodings recover to WAIT on the next edge.

Test Plan:
- Reset, then mode 10, rd=3, s=1 for one edge -> next cycle writenum=3, write=1, vsel=1, w=0. Following cycle: WAIT, w=1, write=0.
- R1=42, R2=7 preloaded; mode 00, rn=1, rm=2, rd=5, aluop_in=00, shift_in=00 -> cycle-by-cycle:
  - readnum=1/loada, then readnum=2/loadb, then loadc+loads, then writenum=5/write.
  - R5 reads 49 afterwards; exactly 4 non-WAIT cycles.
- mode 01, rn=5, rm=5 -> loads=1 in EXEC. write stays 0 for the whole operation; returns to WAIT after 3 cycles.
- mode 11, rm=2, shift_in=01, rd=6 -> asel=1 in EXEC with aluop=00. R6 reads 14 (7 shifted left).
- Busy and back-to-back: pulse s during EXEC of a mode 00 op -> ignored, no extra operation. Hold s=1 through completion -> second op accepted on the first WAIT edge.
- Reset asserted asynchronously (off-edge) in LOAD_B -> outputs drop to WAIT values before the next edge. Target register is unchanged; w=1 after deassert.
